// File: rtl/json_array_encoder.sv
// json_array_encoder: serialises signed integer elements into "[a,b,c]\n" JSON array text on a byte stream
module json_array_encoder #(
    parameter int DATA_W       = 32,
    parameter bit EMIT_NEWLINE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic                     out_last,
    output logic                     busy
);
    function automatic int calc_ndig(input int w);
        logic [63:0] v;
        int n;
        v = 64'd1 << (w - 1);
        n = 0;
        for (int i = 0; i < 20; i++)
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        return n;
    endfunction

    localparam int NDIG = calc_ndig(DATA_W);
    localparam int BW   = 4 * NDIG;
    localparam int PW   = $clog2(NDIG + 1);
    localparam int CW   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, WAIT, PUNCT, SIGN, CONV, DIGITS, CLOSE, NL} state_t;

    state_t               state, state_nxt;
    logic [DATA_W-1:0]    bin;
    logic [BW-1:0]        bcd, bcd_adj;
    logic [BW+DATA_W-1:0] dd_shift;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        ptr, msd, cur;
    logic [3:0]           digit;
    logic                 neg, last_q, open_q, first, started;
    logic                 accept, conv_last;

    assign accept    = in_valid && in_ready;
    assign conv_last = cnt <= CW'(1);
    assign cur       = started ? ptr : msd;
    assign digit     = 4'(bcd >> {cur, 2'b00});
    assign dd_shift  = {bcd_adj, bin} << 1;
    assign busy      = ~first;

    // double-dabble correction: add 3 to every BCD digit of 5 or more before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // most significant nonzero digit, so leading zeros are skipped (0 prints as a single '0')
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIG; i++)
            if (bcd[4*i +: 4] != 4'd0) msd = PW'(i);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and registered-state-decoded outputs; out_valid never looks at out_ready
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        case (state)
            IDLE, WAIT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = PUNCT;
            end
            PUNCT: begin
                out_valid = 1'b1;
                out_byte  = open_q ? 8'h5B : 8'h2C;
                if (out_ready) state_nxt = neg ? SIGN : (conv_last ? DIGITS : CONV);
            end
            SIGN: begin
                out_valid = 1'b1;
                out_byte  = 8'h2D;
                if (out_ready) state_nxt = conv_last ? DIGITS : CONV;
            end
            CONV: state_nxt = conv_last ? DIGITS : CONV;
            DIGITS: begin
                out_valid = 1'b1;
                out_byte  = {4'h3, digit};
                if (out_ready && cur == '0) state_nxt = last_q ? CLOSE : WAIT;
            end
            CLOSE: begin
                out_valid = 1'b1;
                out_byte  = 8'h5D;
                out_last  = !EMIT_NEWLINE;
                if (out_ready) state_nxt = EMIT_NEWLINE ? NL : IDLE;
            end
            NL: begin
                out_valid = 1'b1;
                out_byte  = 8'h0A;
                out_last  = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // element capture, bit-serial conversion running alongside punctuation, digit pointer and document flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            ptr     <= '0;
            neg     <= 1'b0;
            last_q  <= 1'b0;
            open_q  <= 1'b0;
            first   <= 1'b1;
            started <= 1'b0;
        end else begin
            if (accept) begin
                bin     <= in_data[DATA_W-1] ? DATA_W'(-in_data) : DATA_W'(in_data);
                bcd     <= '0;
                cnt     <= CW'(DATA_W);
                neg     <= in_data[DATA_W-1];
                last_q  <= in_last;
                open_q  <= first;
                first   <= 1'b0;
                started <= 1'b0;
            end else if (cnt != '0) begin
                {bcd, bin} <= dd_shift;
                cnt        <= cnt - CW'(1);
            end
            if (state == DIGITS && out_ready) begin
                started <= 1'b1;
                ptr     <= cur - PW'(1);
            end
            if (out_valid && out_ready && out_last) first <= 1'b1;
        end
    end
endmodule

// File: tb/tb_json_array_encoder.sv
// tb_json_array_encoder: scoreboard bench for three encoder configurations (32/NL, 8/NL, 32/no NL)
module tb_json_array_encoder;
    logic        clk, rst_n, iv, ilast, ordy, rnd, chk_lat;
    logic [31:0] idata;
    logic [1:0]  sel;
    logic [2:0]  ov, ir, ol, bz;
    logic [2:0][7:0] ob;
    logic        ov_m, ir_m, ol_m, bz_m;
    logic [7:0]  ob_m;
    logic [8:0]  q[$];
    int          total, bad, cyc, acc_cyc;

    assign ov_m = ov[sel];
    assign ir_m = ir[sel];
    assign ol_m = ol[sel];
    assign bz_m = bz[sel];
    assign ob_m = ob[sel];

    json_array_encoder #(.DATA_W(32), .EMIT_NEWLINE(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd0), .in_ready(ir[0]),
        .in_data(idata), .in_last(ilast), .out_valid(ov[0]), .out_ready(ordy),
        .out_byte(ob[0]), .out_last(ol[0]), .busy(bz[0]));
    json_array_encoder #(.DATA_W(8), .EMIT_NEWLINE(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd1), .in_ready(ir[1]),
        .in_data(idata[7:0]), .in_last(ilast), .out_valid(ov[1]), .out_ready(ordy),
        .out_byte(ob[1]), .out_last(ol[1]), .busy(bz[1]));
    json_array_encoder #(.DATA_W(32), .EMIT_NEWLINE(1'b0)) u32n (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd2), .in_ready(ir[2]),
        .in_data(idata), .in_last(ilast), .out_valid(ov[2]), .out_ready(ordy),
        .out_byte(ob[2]), .out_last(ol[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s, input bit lastf);
        for (int i = 0; i < s.len(); i++)
            q.push_back({lastf && (i == s.len() - 1), s[i]});
    endtask

    task automatic send(input logic [31:0] v, input bit l);
        int t;
        t = 0;
        iv = 1'b1;
        idata = v;
        ilast = l;
        @(negedge clk);
        while (!ir_m && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(ir_m), 32'd1);
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1 t++;
        end
        chk("drain_left", q.size(), 32'd0);
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(bz_m), 32'd0);
        chk("idle_valid", 32'(ov_m), 32'd0);
        chk("idle_ready", 32'(ir_m), 32'd1);
    endtask

    // sink ready: held high, or a coin toss each cycle in random mode
    initial begin
        ordy = 1'b1;
        forever begin
            @(posedge clk);
            #1 ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: pops expected bytes on every handshake, checks hold stability on stalls and first-digit latency
    initial begin
        logic       stall, sl, lat_armed;
        logic [7:0] sb;
        logic [8:0] e;
        stall = 1'b0;
        sl = 1'b0;
        sb = 8'h00;
        lat_armed = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                lat_armed = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 32'(ov_m), 32'd1);
                    chk("stall_byte", 32'(ob_m), 32'(sb));
                    chk("stall_last", 32'(ol_m), 32'(sl));
                end
                if (iv && ir_m) begin
                    acc_cyc = cyc;
                    lat_armed = chk_lat;
                end
                if (ov_m && ordy) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %02h expected none", ob_m);
                    end else begin
                        e = q.pop_front();
                        chk("byte", 32'({ol_m, ob_m}), 32'(e));
                    end
                    if (lat_armed && ob_m >= 8'h30 && ob_m <= 8'h39) begin
                        chk("first_digit_latency", cyc - acc_cyc, 32'd33);
                        lat_armed = 1'b0;
                    end
                end
                stall = ov_m && !ordy;
                sb = ob_m;
                sl = ol_m;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; acc_cyc = 0;
        rst_n = 1'b0; iv = 1'b0; idata = '0; ilast = 1'b0;
        sel = 2'd0; rnd = 1'b0; chk_lat = 1'b0;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_valid", 32'(ov_m), 32'd0);
            chk("rst_byte", 32'(ob_m), 32'd0);
            chk("rst_last", 32'(ol_m), 32'd0);
            chk("rst_busy", 32'(bz_m), 32'd0);
            chk("rst_ready", 32'(ir_m), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sel = 2'd0;
        // single zero element, latency checked
        chk_lat = 1'b1;
        push_str("[0]\n", 1'b1);
        send(32'd0, 1'b1);
        drain();
        chk_lat = 1'b0;
        idle_check();
        // three-element array
        push_str("[12,-3,456]\n", 1'b1);
        send(32'd12, 1'b0);
        send(32'hFFFF_FFFD, 1'b0);
        send(32'd456, 1'b1);
        drain();
        idle_check();
        // same stream with a stalling sink
        rnd = 1'b1;
        push_str("[12,-3,456]\n", 1'b1);
        send(32'd12, 1'b0);
        send(32'hFFFF_FFFD, 1'b0);
        send(32'd456, 1'b1);
        drain();
        rnd = 1'b0;
        idle_check();
        // 8-bit elements including the most negative value
        sel = 2'd1;
        push_str("[-128,127,-1]\n", 1'b1);
        send(32'h80, 1'b0);
        send(32'h7F, 1'b0);
        send(32'hFF, 1'b1);
        drain();
        idle_check();
        // back-to-back documents without newline
        sel = 2'd2;
        push_str("[7]", 1'b1);
        push_str("[8]", 1'b1);
        send(32'd7, 1'b1);
        send(32'd8, 1'b1);
        drain();
        idle_check();
        // reset while the digits of 456 are going out
        sel = 2'd0;
        push_str("[4", 1'b0);
        send(32'd456, 1'b1);
        drain();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov_m), 32'd0);
        chk("midrst_busy", 32'(bz_m), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_str("[9]\n", 1'b1);
        send(32'd9, 1'b1);
        drain();
        idle_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
